// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the ID/EX control stage.
//   - RV32I/RV32M opcode and funct7 constants
//   - alu_op_e (base + M encodings), wb_sel_e, imm_sel_e
//   - ctrl_bundle_t: every registered ex_* control, plus the BUBBLE value
//   - base_alu(): funct3 -> ALU op for the shared R/I-type arithmetic map
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000, ALU_SUB    = 5'b00001, ALU_AND   = 5'b00010,
    ALU_OR     = 5'b00011, ALU_SLL    = 5'b00100, ALU_SLT   = 5'b00101,
    ALU_SRA    = 5'b00111, ALU_SLTU   = 5'b01000, ALU_XOR   = 5'b01010,
    ALU_SRL    = 5'b01011, ALU_LUI    = 5'b01100,
    ALU_MUL    = 5'b10000, ALU_MULH   = 5'b10001, ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011, ALU_DIV    = 5'b10100, ALU_DIVU  = 5'b10101,
    ALU_REM    = 5'b10110, ALU_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00, WB_LOAD = 2'b01, WB_PC4 = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_sel_e;

  typedef struct packed {
    logic     valid;
    logic     illegal;
    logic     mem_wren;
    logic     rd_wren;
    logic     op_a_sel;     // 1: PC as operand A
    logic     op_b_sel;     // 1: immediate as operand B
    logic     br_sel;       // 1: unconditional redirect (jal/jalr)
    logic     br_unsigned;
    logic     slti_sel;
    logic     is_branch;
    wb_sel_e  wb_sel;
    imm_sel_e imm_sel;
    alu_op_e  alu_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  // alt selects sub for funct3=000 and sra for funct3=101
  function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // div/divu/rem/remu share the 101xx prefix
  function automatic logic is_div_op(input alu_op_e op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/rv_decode.sv
// rv_decode: pure combinational RV32I(+M) instruction -> control bundle.
//   i_instr : 32-bit instruction from ID
//   o_ctrl  : decoded bundle; valid is left 0 (the stage owns it).
//             Illegal encodings return an all-zero bundle with illegal=1.
module rv_decode
  import ctrl_pkg::*;
#(
  parameter bit M_EXT = 1'b1
) (
  input  logic [31:0]  i_instr,
  output ctrl_bundle_t o_ctrl
);

  logic [6:0]   w_opcode;
  logic [2:0]   w_f3;
  logic [6:0]   w_f7;
  logic         w_illegal;
  ctrl_bundle_t w_dec;
  logic         w_unused_bits;

  assign w_opcode      = i_instr[6:0];
  assign w_f3          = i_instr[14:12];
  assign w_f7          = i_instr[31:25];
  assign w_unused_bits = ^{i_instr[24:15], i_instr[11:7]};

  always_comb begin
    w_dec     = BUBBLE;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_LOAD: begin
        w_dec.rd_wren  = 1'b1;
        w_dec.op_b_sel = 1'b1;
        w_dec.wb_sel   = WB_LOAD;
      end
      OP_STORE: begin
        w_dec.mem_wren = 1'b1;
        w_dec.op_b_sel = 1'b1;
        w_dec.imm_sel  = IMM_S;
      end
      OP_BRANCH: begin
        w_dec.is_branch   = 1'b1;
        w_dec.op_a_sel    = 1'b1;
        w_dec.op_b_sel    = 1'b1;
        w_dec.imm_sel     = IMM_B;
        w_dec.br_unsigned = w_f3[2] & w_f3[1];  // bltu/bgeu
      end
      OP_IMM: begin
        w_dec.rd_wren     = 1'b1;
        w_dec.op_b_sel    = 1'b1;
        // instr[30] only matters for the right shift; addi has no subtract form
        w_dec.alu_op      = base_alu(w_f3, (w_f3 == 3'b101) & i_instr[30]);
        w_dec.slti_sel    = (w_f3 == 3'b010) | (w_f3 == 3'b011);
        w_dec.br_unsigned = (w_f3 == 3'b011);
      end
      OP_R: begin
        w_dec.rd_wren = 1'b1;
        if (w_f7 == F7_MULDIV) begin
          if (M_EXT) w_dec.alu_op = alu_op_e'({2'b10, w_f3});
          else       w_illegal    = 1'b1;
        end else if (w_f7 == F7_BASE) begin
          w_dec.alu_op      = base_alu(w_f3, 1'b0);
          w_dec.br_unsigned = (w_f3 == 3'b011);
        end else if (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          w_dec.alu_op = base_alu(w_f3, 1'b1);
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_JAL: begin
        w_dec.rd_wren  = 1'b1;
        w_dec.op_a_sel = 1'b1;
        w_dec.op_b_sel = 1'b1;
        w_dec.br_sel   = 1'b1;
        w_dec.wb_sel   = WB_PC4;
        w_dec.imm_sel  = IMM_J;
      end
      OP_JALR: begin
        w_dec.rd_wren  = 1'b1;
        w_dec.op_b_sel = 1'b1;
        w_dec.br_sel   = 1'b1;
        w_dec.wb_sel   = WB_PC4;
      end
      OP_LUI: begin
        w_dec.rd_wren  = 1'b1;
        w_dec.op_b_sel = 1'b1;
        w_dec.imm_sel  = IMM_U;
        w_dec.alu_op   = ALU_LUI;
      end
      OP_AUIPC: begin
        w_dec.rd_wren  = 1'b1;
        w_dec.op_a_sel = 1'b1;
        w_dec.op_b_sel = 1'b1;
        w_dec.imm_sel  = IMM_U;
      end
      default: w_illegal = 1'b1;
    endcase

    if (w_illegal) begin
      w_dec         = BUBBLE;
      w_dec.illegal = 1'b1;
    end
  end

  assign o_ctrl = w_dec;

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage: decodes the ID instruction and registers the control
// bundle into the ID/EX pipeline register; sequences multi-cycle divides.
//   clk, rst         : clock, synchronous active-high reset
//   instr_D, valid_D : instruction in ID and its valid flag
//   stall_i, flush_i : hazard hold / kill into ID/EX
//   stall_D, md_busy : IF/ID freeze and divide-in-progress
//   ex_*             : registered EX-stage controls
module id_ex_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter bit M_EXT    = 1'b1,
  parameter int DIV_LAT  = 8,
  parameter int ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr_D,
  input  logic                valid_D,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                stall_D,
  output logic                md_busy,
  output logic                ex_valid,
  output logic                ex_mem_wren,
  output logic                ex_rd_wren,
  output logic                ex_op_a_sel,
  output logic                ex_op_b_sel,
  output logic                ex_br_sel,
  output logic                ex_br_unsigned,
  output logic                ex_slti_sel,
  output logic                ex_is_branch,
  output logic [1:0]          ex_wb_sel,
  output logic [2:0]          ex_imm_sel,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_illegal
);

  localparam int              CNT_W   = $clog2(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DIV_LAT - 1);

  ctrl_bundle_t     w_dec, w_ld, r_ex;
  logic [CNT_W-1:0] r_cnt;
  logic             w_busy, w_div_ld;

  rv_decode #(.M_EXT(M_EXT)) u_dec (
    .i_instr (instr_D),
    .o_ctrl  (w_dec)
  );

  always_comb begin
    w_ld       = w_dec;
    w_ld.valid = 1'b1;
    if (!valid_D) w_ld = BUBBLE;
  end

  assign w_busy   = (r_cnt != '0);
  // illegal bundles carry alu_op=add, so no separate illegal gate is needed
  assign w_div_ld = valid_D & is_div_op(w_dec.alu_op);

  // The divide issues once; the remaining DIV_LAT-1 EX cycles are bubbles
  // while the counter drains, independent of stall_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= BUBBLE;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_ex  <= BUBBLE;
      r_cnt <= '0;
    end else if (w_busy) begin
      r_ex  <= BUBBLE;
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (!stall_i) begin
      r_ex  <= w_ld;
      r_cnt <= w_div_ld ? CNT_ARM : '0;
    end
  end

  assign md_busy        = w_busy;
  assign stall_D        = w_busy & ~flush_i;
  assign ex_valid       = r_ex.valid;
  assign ex_illegal     = r_ex.illegal;
  assign ex_mem_wren    = r_ex.mem_wren;
  assign ex_rd_wren     = r_ex.rd_wren;
  assign ex_op_a_sel    = r_ex.op_a_sel;
  assign ex_op_b_sel    = r_ex.op_b_sel;
  assign ex_br_sel      = r_ex.br_sel;
  assign ex_br_unsigned = r_ex.br_unsigned;
  assign ex_slti_sel    = r_ex.slti_sel;
  assign ex_is_branch   = r_ex.is_branch;
  assign ex_wb_sel      = r_ex.wb_sel;
  assign ex_imm_sel     = r_ex.imm_sel;

  generate
    if (ALU_OP_W > 5) begin : g_alu_ext
      assign ex_alu_op = {{(ALU_OP_W-5){1'b0}}, r_ex.alu_op};
    end else if (ALU_OP_W == 5) begin : g_alu_eq
      assign ex_alu_op = r_ex.alu_op;
    end else begin : g_alu_trunc
      assign ex_alu_op = r_ex.alu_op[ALU_OP_W-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// tb_id_ex_ctrl_stage: two instances (M_EXT=1/ALU_OP_W=5 and M_EXT=0/ALU_OP_W=6)
// driven in lockstep; directed scenarios followed by random traffic, all
// compared against a table-driven reference model.
module tb_id_ex_ctrl_stage;
  localparam int DL = 8;

  logic        clk = 1'b0;
  logic        rst, valid_D, stall_i, flush_i;
  logic [31:0] instr_D;
  logic [1:0]  stall_D, md_busy, ex_valid, mw, rw, oa, ob, bs, bu, ss, ib, ill;
  logic [1:0][1:0] wb;
  logic [1:0][2:0] imm;
  logic [4:0]  alu0;
  logic [5:0]  alu1;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  id_ex_ctrl_stage #(.M_EXT(1'b1), .DIV_LAT(DL), .ALU_OP_W(5)) dut0 (
    .clk(clk), .rst(rst), .instr_D(instr_D), .valid_D(valid_D), .stall_i(stall_i), .flush_i(flush_i),
    .stall_D(stall_D[0]), .md_busy(md_busy[0]), .ex_valid(ex_valid[0]), .ex_mem_wren(mw[0]),
    .ex_rd_wren(rw[0]), .ex_op_a_sel(oa[0]), .ex_op_b_sel(ob[0]), .ex_br_sel(bs[0]),
    .ex_br_unsigned(bu[0]), .ex_slti_sel(ss[0]), .ex_is_branch(ib[0]), .ex_wb_sel(wb[0]),
    .ex_imm_sel(imm[0]), .ex_alu_op(alu0), .ex_illegal(ill[0]));

  id_ex_ctrl_stage #(.M_EXT(1'b0), .DIV_LAT(DL), .ALU_OP_W(6)) dut1 (
    .clk(clk), .rst(rst), .instr_D(instr_D), .valid_D(valid_D), .stall_i(stall_i), .flush_i(flush_i),
    .stall_D(stall_D[1]), .md_busy(md_busy[1]), .ex_valid(ex_valid[1]), .ex_mem_wren(mw[1]),
    .ex_rd_wren(rw[1]), .ex_op_a_sel(oa[1]), .ex_op_b_sel(ob[1]), .ex_br_sel(bs[1]),
    .ex_br_unsigned(bu[1]), .ex_slti_sel(ss[1]), .ex_is_branch(ib[1]), .ex_wb_sel(wb[1]),
    .ex_imm_sel(imm[1]), .ex_alu_op(alu1), .ex_illegal(ill[1]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit ill, mw, rw, oa, ob, bs, bu, ss, ib, dv; bit [1:0] wb; bit [2:0] imm; int alu; } dec_t;

  function automatic dec_t ref_dec(bit [31:0] ins, bit mext);
    dec_t d = '{default:0};
    bit [6:0] op = ins[6:0];
    bit [2:0] f3 = ins[14:12];
    bit [6:0] f7 = ins[31:25];
    // funct3 -> add sll slt sltu xor srl or and
    int base[8] = '{0, 4, 5, 8, 10, 11, 3, 2};
    case (op)
      7'h03: begin d.rw = 1; d.ob = 1; d.wb = 1; end
      7'h23: begin d.mw = 1; d.ob = 1; d.imm = 1; end
      7'h63: begin d.ib = 1; d.oa = 1; d.ob = 1; d.imm = 2; d.bu = (f3 == 6 || f3 == 7); end
      7'h13: begin
        d.rw = 1; d.ob = 1; d.alu = base[f3];
        if (f3 == 5 && ins[30]) d.alu = 7;
        d.ss = (f3 == 2 || f3 == 3); d.bu = (f3 == 3);
      end
      7'h33: begin
        d.rw = 1;
        if (f7 == 1) begin
          if (mext) begin d.alu = 16 + f3; d.dv = (f3 >= 4); end
          else d.ill = 1;
        end else if (f7 == 0) begin
          d.alu = base[f3]; d.bu = (f3 == 3);
        end else if (f7 == 7'h20 && f3 == 0) d.alu = 1;
        else if (f7 == 7'h20 && f3 == 5) d.alu = 7;
        else d.ill = 1;
      end
      7'h6f: begin d.rw = 1; d.oa = 1; d.ob = 1; d.bs = 1; d.wb = 3; d.imm = 3; end
      7'h67: begin d.rw = 1; d.ob = 1; d.bs = 1; d.wb = 3; end
      7'h37: begin d.rw = 1; d.ob = 1; d.imm = 4; d.alu = 12; end
      7'h17: begin d.rw = 1; d.oa = 1; d.ob = 1; d.imm = 4; end
      default: d.ill = 1;
    endcase
    if (d.ill) begin d = '{default:0}; d.ill = 1; end
    return d;
  endfunction

  function automatic logic [31:0] pack(dec_t d);
    logic [5:0] a = 6'(d.alu);
    return {11'b0, 1'b1, d.ill, d.mw, d.rw, d.oa, d.ob, d.bs, d.bu, d.ss, d.ib, d.wb, d.imm, a};
  endfunction

  function automatic logic [31:0] act_vec(int k);
    logic [5:0] a = (k == 0) ? {1'b0, alu0} : alu1;
    return {11'b0, ex_valid[k], ill[k], mw[k], rw[k], oa[k], ob[k], bs[k], bu[k], ss[k], ib[k],
            wb[k], imm[k], a};
  endfunction

  logic [31:0] exp_vec[2];
  int          cnt[2];
  bit          mext[2] = '{1'b1, 1'b0};
  bit          hold = 1'b0;   // IF/ID frozen at the last edge

  task automatic model_step();
    dec_t d;
    hold = (cnt[0] != 0) && !flush_i;
    for (int k = 0; k < 2; k++) begin
      if (rst || flush_i) begin exp_vec[k] = '0; cnt[k] = 0; end
      else if (cnt[k] > 0) begin exp_vec[k] = '0; cnt[k]--; end
      else if (!stall_i) begin
        if (valid_D) begin
          d = ref_dec(instr_D, mext[k]);
          exp_vec[k] = pack(d);
          cnt[k] = d.dv ? DL - 1 : 0;
        end else exp_vec[k] = '0;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] ins, input logic v, input logic st,
                       input logic fl, input logic rs);
    rst = rs; stall_i = st; flush_i = fl;
    if (!hold) begin instr_D = ins; valid_D = v; end
  endtask

  // called at negedge with inputs applied: check, then advance one edge
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ctrl[%0d]", k), act_vec(k), exp_vec[k]);
      chk($sformatf("md_busy[%0d]", k), 32'(md_busy[k]), 32'(cnt[k] != 0));
      chk($sformatf("stall_D[%0d]", k), 32'(stall_D[k]), 32'((cnt[k] != 0) && !flush_i));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops[9] = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6f, 7'h67, 7'h37, 7'h17};
    logic [31:0] r = $urandom;
    int          s = $urandom_range(0, 9);
    if (s == 9) return r;
    r[6:0] = ops[s];
    if (ops[s] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    return r;
  endfunction

  logic [31:0] ADDI, SUB, SLTIU, DIV, LW, BLTU;

  initial begin
    ADDI  = 32'h00500093;
    SUB   = 32'h402081B3;
    SLTIU = {12'd7, 5'd1, 3'b011, 5'd4, 7'b0010011};
    DIV   = 32'h027342B3;
    LW    = {12'd4, 5'd1, 3'b010, 5'd3, 7'b0000011};
    BLTU  = {7'd0, 5'd2, 5'd1, 3'b110, 5'b01000, 7'b1100011};
    cnt = '{0, 0}; exp_vec = '{32'h0, 32'h0};
    rst = 1'b1; valid_D = 1'b0; stall_i = 1'b0; flush_i = 1'b0; instr_D = '0;
    @(posedge clk); model_step(); @(negedge clk);
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();   // reset state

    // addi -> sub -> sltiu
    drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(SUB, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("addi_valid", 32'(ex_valid[0]), 32'd1);
    chk("addi_rdw", 32'(rw[0]), 32'd1);
    chk("addi_opb", 32'(ob[0]), 32'd1);
    chk("addi_alu", 32'(alu0), 32'd0);
    chk("addi_imm_wb", {27'd0, imm[0], wb[0]}, 32'd0);
    tick();
    drive(SLTIU, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("sub_alu", 32'(alu0), 32'b00001);
    tick();
    drive(DIV, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("sltiu_alu", 32'(alu0), 32'b01000);
    chk("sltiu_sel", {30'd0, ss[0], bu[0]}, 32'b11);
    tick();

    // divide: 1 op cycle, 7 busy/bubble cycles, follower in EX at cycle 9
    for (int c = 1; c <= 9; c++) begin
      drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      if (c == 1) begin
        chk("div_alu", 32'(alu0), 32'b10100);
        chk("nom_div_ill", 32'(ill[1]), 32'd1);
        chk("nom_div_rdw", 32'(rw[1]), 32'd0);
        chk("nom_div_stall", 32'(stall_D[1]), 32'd0);
      end
      chk("div_busy", 32'(md_busy[0]), 32'(c <= 7));
      if (c >= 2 && c <= 8) chk("div_bubble", 32'(ex_valid[0]), 32'd0);
      if (c == 9) chk("div_follow", {26'd0, ex_valid[0], alu0}, 32'b100000);
      tick();
    end

    drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("zero_ill", {30'd0, ill}, 32'b11);
    tick();

    // flush at count 4
    drive(DIV, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    for (int c = 1; c <= 4; c++) begin
      drive(ADDI, 1'b1, 1'b0, c == 4, 1'b0); #1;
      if (c == 4) chk("flush_stall", {30'd0, stall_D[0], md_busy[0]}, 32'b01);
      tick();
    end
    drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("flush_after", {30'd0, md_busy[0], ex_valid[0]}, 32'b00);
    tick();

    // reset mid-divide
    drive(DIV, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    for (int c = 1; c <= 3; c++) begin drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b0); tick(); end
    drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("rst_div_stall", {30'd0, stall_D[0], md_busy[0]}, 32'b00);
    chk("rst_div_ctrl", act_vec(0), 32'h0);
    tick();

    // stall_i holds lw in EX, then bltu loads
    drive(LW, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(BLTU, 1'b1, 1'b1, 1'b0, 1'b0); #1;
      chk("stall_lw_wb", {29'd0, ex_valid[0], wb[0]}, 32'b101);
      tick();
    end
    drive(BLTU, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(ADDI, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("bltu_ctrl", {27'd0, bu[0], ib[0], imm[0]}, 32'b11010);
    tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(rnd_instr(), $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
